// File: rtl/datapath_legv8_param.sv
// ---------------------------------------------------------------------------
// datapath_legv8_param
//
// Parameterised LEGv8 datapath: register file, PC, IR, status register and a
// single internal data bus, with the ALU kept outside this block. Bus sources
// come from encoded selects, so only one source can ever drive the bus. A
// small req/ack FSM runs memory transactions; while a transaction is pending
// the datapath stalls, and a sticky error flags a transaction that timed out.
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   constant               immediate from control (DW)
//   DA, SA, SB             destination / A-source / B-source register index
//   W, IL, SL              register write, IR load, SR load enables
//   PS, PCsel              PC op (hold, +4, load, relative) and load source
//   Bsel                   ALU B operand: B bus or constant
//   data_sel               data bus source: rd latch, alu_f, B bus, PC
//   addr_sel               memory address source: PC or alu_f
//   mem_rd, mem_wr         memory operation request from control
//   alu_a, alu_b           operands to the external ALU
//   alu_f, alu_status      result and flags from the external ALU
//   mem_req, mem_we        registered memory request / write strobe
//   mem_addr, mem_wdata    registered memory address / write data
//   mem_rdata, mem_ack     memory read data / completion
//   stall                  architectural updates frozen this cycle
//   mem_err                sticky transaction timeout flag
//   data                   internal data bus (observation)
//   IR_out, SR_out, pc_out instruction register, status register, PC
// ---------------------------------------------------------------------------
module datapath_legv8_param #(
  parameter int            DW             = 64,
  parameter int            AW             = 32,
  parameter int            NREG           = 32,
  parameter bit            XZR_EN         = 1'b1,
  parameter logic [AW-1:0] PC_RESET_VALUE = '0,
  parameter int            TIMEOUT        = 255,
  localparam int           RW             = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] constant,
  input  logic [RW-1:0] DA,
  input  logic [RW-1:0] SA,
  input  logic [RW-1:0] SB,
  input  logic          W,
  input  logic          IL,
  input  logic          SL,
  input  logic [1:0]    PS,
  input  logic          PCsel,
  input  logic          Bsel,
  input  logic [1:0]    data_sel,
  input  logic          addr_sel,
  input  logic          mem_rd,
  input  logic          mem_wr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_f,
  input  logic [3:0]    alu_status,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          mem_err,
  output logic [DW-1:0] data,
  output logic [31:0]   IR_out,
  output logic [3:0]    SR_out,
  output logic [AW-1:0] pc_out
);

  localparam logic [RW-1:0] XZR_IDX  = RW'(NREG - 1);
  // The counter only needs to reach TIMEOUT-1: the last WAIT cycle is the
  // one where it already holds TIMEOUT-1 and no ack arrived.
  localparam int            TCW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } mem_state_e;

  mem_state_e     state_q, state_d;
  logic           start_op;
  logic           ack_take;
  logic           time_out;
  logic [TCW-1:0] tmo_cnt_q;

  logic [DW-1:0]  rf_q [NREG];
  logic [DW-1:0]  a_bus;
  logic [DW-1:0]  b_bus;
  logic [DW-1:0]  rd_latch_q;
  logic [AW-1:0]  pc_q;
  logic [AW-1:0]  pc_d;
  logic [31:0]    ir_q;
  logic [3:0]     sr_q;

  // -------------------------------------------------------------------------
  // Register file reads and ALU operands
  // -------------------------------------------------------------------------
  assign a_bus = (XZR_EN && SA == XZR_IDX) ? '0 : rf_q[SA];
  assign b_bus = (XZR_EN && SB == XZR_IDX) ? '0 : rf_q[SB];

  assign alu_a = a_bus;
  assign alu_b = Bsel ? constant : b_bus;

  // -------------------------------------------------------------------------
  // Internal data bus: one encoded select, so a single driver by construction
  // -------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    data = '0;
    unique case (data_sel)
      2'b00:   data = rd_latch_q;
      2'b01:   data = alu_f;
      2'b10:   data = b_bus;
      default: data = DW'(pc_q);
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory handshake FSM: next state and decoded events
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    start_op = 1'b0;
    ack_take = 1'b0;
    time_out = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_rd || mem_wr) begin
          start_op = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          ack_take = 1'b1;
          state_d  = ST_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          time_out = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The request cycle itself is frozen, so the address and write data latched
  // into the memory registers come from a datapath that cannot move under them.
  assign stall = start_op | (state_q == ST_WAIT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory interface registers, read latch, timeout counter, error flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_latch_q <= '0;
      mem_err    <= 1'b0;
      tmo_cnt_q  <= '0;
    end else if (start_op) begin
      mem_req   <= 1'b1;
      mem_we    <= mem_wr & ~mem_rd;  // a read wins if both are requested
      mem_addr  <= addr_sel ? alu_f[AW-1:0] : pc_q;
      mem_wdata <= data;
      tmo_cnt_q <= '0;
    end else if (ack_take) begin
      mem_req <= 1'b0;
      if (!mem_we) begin
        rd_latch_q <= mem_rdata;
      end
    end else if (time_out) begin
      mem_req <= 1'b0;
      mem_err <= 1'b1;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + TCW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Register file write
  // -------------------------------------------------------------------------
  // NOTE: the register array is reset explicitly because the architecture
  // requires every register to read zero after reset; this keeps it in flops
  // rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (W && !stall && !(XZR_EN && DA == XZR_IDX)) begin
      rf_q[DA] <= data;
    end
  end

  // -------------------------------------------------------------------------
  // Program counter; all arithmetic wraps at AW bits
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_q;
    unique case (PS)
      2'b00:   pc_d = pc_q;
      2'b01:   pc_d = pc_q + AW'(4);
      2'b10:   pc_d = PCsel ? constant[AW-1:0] : a_bus[AW-1:0];
      default: pc_d = pc_q + (constant[AW-1:0] << 2);
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET_VALUE;
      ir_q <= '0;
      sr_q <= '0;
    end else if (!stall) begin
      pc_q <= pc_d;
      if (IL) begin
        ir_q <= data[31:0];
      end
      if (SL) begin
        sr_q <= alu_status;
      end
    end
  end

  assign pc_out = pc_q;
  assign IR_out = ir_q;
  assign SR_out = sr_q;

endmodule

// File: tb/tb_datapath_legv8_param.sv
// ---------------------------------------------------------------------------
// tb_datapath_legv8_param
//
// Drives control words into the datapath and compares against a transaction-
// level model of the architecture (register array, PC, IR, SR, one outstanding
// memory transaction). Expected memory requests are queued when issued; a
// monitor pops one per rising mem_req and holds it for the whole request.
// ---------------------------------------------------------------------------
module tb_datapath_legv8_param;

  localparam int          DW         = 64;
  localparam int          AW         = 32;
  localparam int          TB_TIMEOUT = 4;
  localparam logic [31:0] PC_RST     = 32'h0;

  typedef struct {
    logic [4:0]  da, sa, sb;
    logic        w, il, sl;
    logic [1:0]  ps;
    logic        pcsel, bsel;
    logic [1:0]  data_sel;
    logic        addr_sel, rd, wr, ack;
    logic [63:0] cst, f, rdata;
    logic [3:0]  status;
  } ctl_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
  } txn_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   constant;
  logic [4:0]    DA, SA, SB;
  logic          W, IL, SL;
  logic [1:0]    PS;
  logic          PCsel, Bsel;
  logic [1:0]    data_sel;
  logic          addr_sel, mem_rd, mem_wr;
  logic [63:0]   alu_a, alu_b, alu_f;
  logic [3:0]    alu_status;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
  logic          mem_ack, stall, mem_err;
  logic [63:0]   data;
  logic [31:0]   IR_out;
  logic [3:0]    SR_out;
  logic [31:0]   pc_out;

  datapath_legv8_param #(
    .DW(DW), .AW(AW), .NREG(32), .XZR_EN(1'b1),
    .PC_RESET_VALUE(PC_RST), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .constant(constant),
    .DA(DA), .SA(SA), .SB(SB), .W(W), .IL(IL), .SL(SL),
    .PS(PS), .PCsel(PCsel), .Bsel(Bsel), .data_sel(data_sel),
    .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_status(alu_status),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .mem_err(mem_err), .data(data),
    .IR_out(IR_out), .SR_out(SR_out), .pc_out(pc_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_reg [32];
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [3:0]  m_sr;
  logic [63:0] m_latch;
  logic        m_err;
  logic        m_pending;   // a memory transaction is outstanding
  logic        m_done;      // the cycle right after a transaction finished
  logic        m_is_rd;
  int          m_waits;
  txn_t        exp_q [$];
  int          stall_cnt;
  int          req_cnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = PC_RST; m_ir = '0; m_sr = '0; m_latch = '0; m_err = 1'b0;
    m_pending = 1'b0; m_done = 1'b0; m_is_rd = 1'b0; m_waits = 0;
  endtask

  function automatic logic [63:0] m_rd(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : m_reg[i];
  endfunction

  function automatic ctl_t idle_ctl();
    ctl_t c;
    c.da = '0; c.sa = '0; c.sb = '0; c.w = 0; c.il = 0; c.sl = 0; c.ps = 2'b00;
    c.pcsel = 0; c.bsel = 0; c.data_sel = 2'b01; c.addr_sel = 0;
    c.rd = 0; c.wr = 0; c.ack = 0;
    c.cst = {$urandom, $urandom}; c.f = {$urandom, $urandom};
    c.rdata = {$urandom, $urandom}; c.status = 4'($urandom);
    return c;
  endfunction

  function automatic ctl_t rand_ctl();
    ctl_t c;
    c = idle_ctl();
    c.da = 5'($urandom); c.sa = 5'($urandom); c.sb = 5'($urandom);
    c.w = 1'($urandom); c.il = 1'($urandom); c.sl = 1'($urandom);
    c.ps = 2'($urandom); c.pcsel = 1'($urandom); c.bsel = 1'($urandom);
    c.data_sel = 2'($urandom); c.addr_sel = 1'($urandom);
    c.ack = 1'($urandom);   // stray acks outside a transaction must be ignored
    return c;
  endfunction

  task automatic drive(input ctl_t c);
    DA = c.da; SA = c.sa; SB = c.sb; W = c.w; IL = c.il; SL = c.sl;
    PS = c.ps; PCsel = c.pcsel; Bsel = c.bsel; data_sel = c.data_sel;
    addr_sel = c.addr_sel; mem_rd = c.rd; mem_wr = c.wr; mem_ack = c.ack;
    constant = c.cst; alu_f = c.f; mem_rdata = c.rdata; alu_status = c.status;
  endtask

  // One clock cycle: drive at posedge+1, check combinational outputs at the
  // negedge, advance the model, check registered state at the next posedge+1.
  task automatic run(input ctl_t c);
    logic [63:0] a, b, d;
    logic        start, exp_stall;
    drive(c);
    a = m_rd(c.sa);
    b = m_rd(c.sb);
    case (c.data_sel)
      2'b00:   d = m_latch;
      2'b01:   d = c.f;
      2'b10:   d = b;
      default: d = {32'd0, m_pc};
    endcase
    start     = !m_pending && !m_done && (c.rd || c.wr);
    exp_stall = m_pending || start;
    @(negedge clock);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, c.bsel ? c.cst : b);
    check("data", data, d);
    check("stall", {63'd0, stall}, {63'd0, exp_stall});
    if (stall) stall_cnt++;
    if (mem_req) req_cnt++;
    if (!exp_stall) begin
      if (c.w && c.da != 5'd31) m_reg[c.da] = d;
      if (c.il) m_ir = d[31:0];
      if (c.sl) m_sr = c.status;
      case (c.ps)
        2'b01:   m_pc = m_pc + 32'd4;
        2'b10:   m_pc = c.pcsel ? c.cst[31:0] : a[31:0];
        2'b11:   m_pc = m_pc + (c.cst[31:0] << 2);
        default: m_pc = m_pc;
      endcase
    end
    if (m_pending) begin
      if (c.ack) begin
        if (m_is_rd) m_latch = c.rdata;
        m_pending = 1'b0; m_done = 1'b1;
      end else begin
        m_waits++;
        if (m_waits == TB_TIMEOUT) begin
          m_err = 1'b1; m_pending = 1'b0; m_done = 1'b1;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      m_pending = 1'b1; m_waits = 0; m_is_rd = c.rd;
      exp_q.push_back('{we: (c.wr && !c.rd),
                        addr: (c.addr_sel ? c.f[31:0] : m_pc),
                        wdata: d});
    end
    @(posedge clock);
    #1;
    check("pc_out", {32'd0, pc_out}, {32'd0, m_pc});
    check("IR_out", {32'd0, IR_out}, {32'd0, m_ir});
    check("SR_out", {60'd0, SR_out}, {60'd0, m_sr});
    check("mem_err", {63'd0, mem_err}, {63'd0, m_err});
    check("mem_req", {63'd0, mem_req}, {63'd0, m_pending});
  endtask

  // Request cycle plus WAIT cycles; ack_at = k acks in the k-th WAIT cycle,
  // 0 never acks. The DONE cycle is left to the caller.
  task automatic mem_txn(input ctl_t c, input int ack_at);
    ctl_t w;
    int   k;
    run(c);
    k = 0;
    while (m_pending && k < TB_TIMEOUT + 2) begin
      k++;
      w = c;
      w.ack = (k == ack_at);
      w.rdata = (k == ack_at) ? c.rdata : {$urandom, $urandom};
      run(w);
    end
  endtask

  task automatic sweep_regs();
    ctl_t c;
    for (int i = 0; i < 32; i++) begin
      c = idle_ctl();
      c.sa = 5'(i);
      c.sb = 5'(31 - i);
      run(c);
    end
  endtask

  // ---------------- monitor ----------------
  txn_t cur;
  logic prev_req = 1'b0;

  always @(negedge clock) begin
    if (mem_req && !prev_req) begin
      check("req_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
    end
    if (mem_req) begin
      check("mem_we", {63'd0, mem_we}, {63'd0, cur.we});
      check("mem_addr", {32'd0, mem_addr}, {32'd0, cur.addr});
      check("mem_wdata", mem_wdata, cur.wdata);
    end
    prev_req = mem_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    ctl_t c;
    logic [31:0] pc0;
    model_reset();
    drive(idle_ctl());
    repeat (3) @(posedge clock);
    #1;
    check("rst_pc", {32'd0, pc_out}, {32'd0, PC_RST});
    check("rst_ir", {32'd0, IR_out}, 64'd0);
    check("rst_sr", {60'd0, SR_out}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_err", {63'd0, mem_err}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b1;

    // PC increments from reset
    for (int i = 0; i < 3; i++) begin
      c = idle_ctl(); c.ps = 2'b01; run(c);
    end
    check("pc_after_3", {32'd0, pc_out}, 64'd12);
    sweep_regs();

    // ALU result into reg5; write to XZR dropped
    c = idle_ctl(); c.data_sel = 2'b01; c.f = 64'hDEAD; c.da = 5'd5; c.w = 1; run(c);
    c = idle_ctl(); c.sa = 5'd5; run(c);
    check("reg5_dead", alu_a, 64'hDEAD);
    c = idle_ctl(); c.data_sel = 2'b01; c.f = 64'hBEEF; c.da = 5'd31; c.w = 1; run(c);
    c = idle_ctl(); c.sa = 5'd31; run(c);
    check("xzr_zero", alu_a, 64'd0);

    // read with ack in the third WAIT cycle, PS=01 held throughout
    stall_cnt = 0; req_cnt = 0; pc0 = m_pc;
    c = idle_ctl(); c.rd = 1; c.addr_sel = 0; c.ps = 2'b01; c.rdata = 64'h1234;
    mem_txn(c, 3);
    c = idle_ctl(); c.data_sel = 2'b00; c.da = 5'd2; c.w = 1; c.ps = 2'b01; run(c);
    check("rd_stall_cycles", 64'(stall_cnt), 64'd4);
    check("rd_req_cycles", 64'(req_cnt), 64'd3);
    check("pc_only_done", {32'd0, pc_out}, {32'd0, pc0 + 32'd4});
    c = idle_ctl(); c.sa = 5'd2; run(c);
    check("reg2_rdata", alu_a, 64'h1234);

    // write of reg3 to an ALU-computed address
    c = idle_ctl(); c.data_sel = 2'b01; c.f = 64'h55; c.da = 5'd3; c.w = 1; run(c);
    c = idle_ctl(); c.wr = 1; c.data_sel = 2'b10; c.sb = 5'd3; c.addr_sel = 1;
    c.f = 64'hABCD_0000_1234_5678;
    mem_txn(c, 2);
    run(idle_ctl());

    // timeout: no ack, error is sticky
    c = idle_ctl(); c.rd = 1;
    mem_txn(c, 0);
    check("timeout_err", {63'd0, mem_err}, 64'd1);
    run(idle_ctl());
    repeat (3) run(idle_ctl());
    check("err_sticky", {63'd0, mem_err}, 64'd1);

    // PC relative and wrap
    c = idle_ctl(); c.ps = 2'b10; c.pcsel = 1; c.cst = 64'h100; run(c);
    c = idle_ctl(); c.ps = 2'b11; c.cst = 64'hFFFF_FFFF_FFFF_FFFE; run(c);
    check("pc_rel_neg", {32'd0, pc_out}, 64'hF8);
    c = idle_ctl(); c.ps = 2'b10; c.pcsel = 1; c.cst = 64'hFFFF_FFFC; run(c);
    c = idle_ctl(); c.ps = 2'b01; run(c);
    check("pc_wrap", {32'd0, pc_out}, 64'd0);

    // randomized mix of datapath cycles and memory transactions
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(4, 0) == 0) begin
        c = rand_ctl();
        c.rd = 1'($urandom);
        c.wr = !c.rd | 1'($urandom);
        mem_txn(c, int'($urandom_range(6, 0)));
        run(rand_ctl());
      end else begin
        run(rand_ctl());
      end
    end
    sweep_regs();

    // reset asserted in the middle of WAIT
    c = idle_ctl(); c.rd = 1; c.ps = 2'b01;
    run(c);
    c.ack = 0;
    run(c);
    mem_rd = 1'b0; mem_wr = 1'b0; W = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("abort_mem_req", {63'd0, mem_req}, 64'd0);
    check("abort_pc", {32'd0, pc_out}, {32'd0, PC_RST});
    check("abort_mem_err", {63'd0, mem_err}, 64'd0);
    check("abort_stall", {63'd0, stall}, 64'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    sweep_regs();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
